// File: rtl/mips_cpu_alu_pkg.sv
// Shared op codes and helpers for the EX-stage ALU / multiply-divide unit.
package mips_cpu_alu_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 5'd0,
        OP_OR    = 5'd1,
        OP_ADD   = 5'd2,
        OP_SUB   = 5'd3,
        OP_SLT   = 5'd4,
        OP_XOR   = 5'd5,
        OP_SLL   = 5'd6,
        OP_SRL   = 5'd7,
        OP_SRA   = 5'd8,
        OP_SLLV  = 5'd9,
        OP_SRLV  = 5'd10,
        OP_SRAV  = 5'd11,
        OP_LUI   = 5'd12,
        OP_SLTU  = 5'd13,
        OP_PASS  = 5'd14,
        OP_MULT  = 5'd15,
        OP_MULTU = 5'd16,
        OP_DIV   = 5'd17,
        OP_DIVU  = 5'd18,
        OP_MFHI  = 5'd19,
        OP_MFLO  = 5'd20,
        OP_MTHI  = 5'd21,
        OP_MTLO  = 5'd22
    } alu_op_t;

    // first op code that touches HI/LO; everything below is a plain ALU op
    localparam logic [OP_W-1:0] MDU_FIRST = 5'd15;

    // true for the four ops that launch the iterative engine
    function automatic logic is_mdu_start(input logic [OP_W-1:0] op);
        return (op >= MDU_FIRST) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_cpu_alu_mdu_if.sv
// Operand / result bundle between operand muxing and the execute unit.
interface mips_cpu_alu_mdu_if
    import mips_cpu_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   sa;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             md_done;

    modport master (
        output op, a, b, sa, in_valid,
        input  in_ready, result, out_valid, zero, hi, lo, busy, md_done
    );

    modport slave (
        input  op, a, b, sa, in_valid,
        output in_ready, result, out_valid, zero, hi, lo, busy, md_done
    );

endinterface

// File: rtl/mips_cpu_mdu.sv
// Iterative radix-2 multiply/divide engine; owns HI/LO.
module mips_cpu_mdu
    import mips_cpu_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_hi_we,
    input  logic             mt_lo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_RUN  = 1'b1;

    logic [0:0]       state_q, state_n;
    logic [DW-1:0]    acc_q, acc_n;
    logic [WIDTH-1:0] dvs_q, dvs_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             is_div_q, is_div_n;
    logic             neg_q_q, neg_q_n;
    logic             neg_r_q, neg_r_n;
    logic             div0_q, div0_n;
    logic [WIDTH-1:0] hi_q, hi_n;
    logic [WIDTH-1:0] lo_q, lo_n;
    logic             done_q, done_n;

    logic             div_c, sgn_c, a_neg_c, b_neg_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [WIDTH:0]   mul_sum_c, div_t_c, div_diff_c;
    logic             div_ge_c;
    logic [DW-1:0]    step_c, prod_c;
    logic [WIDTH-1:0] quo_c, rem_c, fin_hi_c, fin_lo_c;

    // operand decode: the engine works on magnitudes, signs are fixed up at the end
    assign div_c   = (op == OP_DIV) || (op == OP_DIVU);
    assign sgn_c   = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg_c = sgn_c && a[WIDTH-1];
    assign b_neg_c = sgn_c && b[WIDTH-1];
    assign mag_a_c = a_neg_c ? -a : a;
    assign mag_b_c = b_neg_c ? -b : b;

    // one shift-add / restoring-subtract step plus the final sign fix-up
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        div_t_c    = acc_q[DW-1:WIDTH-1];
        div_diff_c = div_t_c - {1'b0, dvs_q};
        div_ge_c   = (div_t_c >= {1'b0, dvs_q});
        if (is_div_q) begin
            step_c = {(div_ge_c ? div_diff_c[WIDTH-1:0] : div_t_c[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge_c};
        end else begin
            step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
        end
        quo_c  = step_c[WIDTH-1:0];
        rem_c  = step_c[DW-1:WIDTH];
        prod_c = neg_q_q ? -step_c : step_c;
        if (is_div_q) begin
            // divide by zero leaves the raw dividend as remainder; quotient forced to ones
            fin_lo_c = div0_q ? '1 : (neg_q_q ? -quo_c : quo_c);
            fin_hi_c = neg_r_q ? -rem_c : rem_c;
        end else begin
            fin_hi_c = prod_c[DW-1:WIDTH];
            fin_lo_c = prod_c[WIDTH-1:0];
        end
    end

    // next-state: load on start, iterate WIDTH times, commit HI/LO on the last step
    always_comb begin
        state_n  = state_q;
        acc_n    = acc_q;
        dvs_n    = dvs_q;
        cnt_n    = cnt_q;
        is_div_n = is_div_q;
        neg_q_n  = neg_q_q;
        neg_r_n  = neg_r_q;
        div0_n   = div0_q;
        hi_n     = hi_q;
        lo_n     = lo_q;
        done_n   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_RUN;
                    cnt_n    = '0;
                    is_div_n = div_c;
                    neg_q_n  = a_neg_c ^ b_neg_c;
                    neg_r_n  = div_c && a_neg_c;
                    div0_n   = div_c && (b == '0);
                    acc_n    = div_c ? {{WIDTH{1'b0}}, mag_a_c} : {{WIDTH{1'b0}}, mag_b_c};
                    dvs_n    = div_c ? mag_b_c : mag_a_c;
                end
            end
            S_RUN: begin
                acc_n = step_c;
                cnt_n = CW'(cnt_q + CW'(1));
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_n = S_IDLE;
                    hi_n    = fin_hi_c;
                    lo_n    = fin_lo_c;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (mt_hi_we) hi_n = mt_data;
        if (mt_lo_we) lo_n = mt_data;
    end

    // engine and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            acc_q    <= acc_n;
            dvs_q    <= dvs_n;
            cnt_q    <= cnt_n;
            is_div_q <= is_div_n;
            neg_q_q  <= neg_q_n;
            neg_r_q  <= neg_r_n;
            div0_q   <= div0_n;
            hi_q     <= hi_n;
            lo_q     <= lo_n;
            done_q   <= done_n;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/mips_cpu_alu_mdu.sv
// EX-stage execute unit: single-cycle ALU, HI/LO moves and the iterative MDU.
module mips_cpu_alu_mdu
    import mips_cpu_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_cpu_alu_mdu_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned HW  = WIDTH / 2;

    logic [WIDTH-1:0] result_q, result_n, alu_c;
    logic             out_valid_q, out_valid_n;
    logic             accept_c, md_start_c, mt_hi_we_c, mt_lo_we_c;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;

    // only HI/LO users stall behind a running multiply/divide
    assign bus.in_ready = !md_busy || (bus.op < MDU_FIRST);
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign md_start_c   = accept_c && is_mdu_start(bus.op);
    assign mt_hi_we_c   = accept_c && (bus.op == OP_MTHI);
    assign mt_lo_we_c   = accept_c && (bus.op == OP_MTLO);

    // ALU result selection; non-result ops hold the previous value
    always_comb begin
        alu_c = result_q;
        case (bus.op)
            OP_AND:  alu_c = bus.a & bus.b;
            OP_OR:   alu_c = bus.a | bus.b;
            OP_ADD:  alu_c = bus.a + bus.b;
            OP_SUB:  alu_c = bus.a - bus.b;
            OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_XOR:  alu_c = bus.a ^ bus.b;
            OP_SLL:  alu_c = bus.b << bus.sa;
            OP_SRL:  alu_c = bus.b >> bus.sa;
            OP_SRA:  alu_c = WIDTH'($signed(bus.b) >>> bus.sa);
            OP_SLLV: alu_c = bus.b << bus.a[SHW-1:0];
            OP_SRLV: alu_c = bus.b >> bus.a[SHW-1:0];
            OP_SRAV: alu_c = WIDTH'($signed(bus.b) >>> bus.a[SHW-1:0]);
            OP_LUI:  alu_c = {bus.b[HW-1:0], {HW{1'b0}}};
            OP_SLTU: alu_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_PASS: alu_c = bus.a;
            OP_MFHI: alu_c = md_hi;
            OP_MFLO: alu_c = md_lo;
            default: alu_c = result_q;
        endcase
    end

    // next result / out_valid: every accepted op except an MDU start pulses out_valid
    always_comb begin
        result_n    = result_q;
        out_valid_n = 1'b0;
        if (accept_c) begin
            result_n    = alu_c;
            out_valid_n = !is_mdu_start(bus.op);
        end
    end

    // result register and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_n;
            out_valid_q <= out_valid_n;
        end
    end

    mips_cpu_mdu #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (md_start_c),
        .op       (bus.op),
        .a        (bus.a),
        .b        (bus.b),
        .mt_hi_we (mt_hi_we_c),
        .mt_lo_we (mt_lo_we_c),
        .mt_data  (bus.a),
        .busy     (md_busy),
        .done     (md_done),
        .hi       (md_hi),
        .lo       (md_lo)
    );

    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;
    assign bus.zero      = (result_q == '0);
    assign bus.hi        = md_hi;
    assign bus.lo        = md_lo;
    assign bus.busy      = md_busy;
    assign bus.md_done   = md_done;

endmodule
